// File: rtl/sr04_echo_emu.sv
// HC-SR04 sensor emulator: answers a trig pulse with an echo whose
// width encodes a programmable target distance.
module sr04_echo_emu #(
    parameter int TRIG_MIN    = 500,
    parameter int BURST_CYC   = 10000,
    parameter int CYC_PER_CM  = 2900,
    parameter int MAX_CM      = 200,
    parameter int TIMEOUT_CYC = 1900000,
    parameter int HOLDOFF_CYC = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       trig,
    input  logic [7:0] distance_cm,
    output logic       echo,
    output logic       busy,
    output logic       done,
    output logic       short_trig
);

    localparam int CW = 24;
    localparam int WW = $clog2(TRIG_MIN + 1);

    localparam logic [WW-1:0] WMAX      = WW'(TRIG_MIN);
    localparam logic [CW-1:0] BURST_END = CW'(BURST_CYC - 1);
    localparam logic [CW-1:0] HOLD_END  = CW'(HOLDOFF_CYC - 1);
    localparam logic [CW-1:0] CPC       = CW'(CYC_PER_CM);
    localparam logic [CW-1:0] TMO       = CW'(TIMEOUT_CYC);
    localparam logic [7:0]    MAX_L     = 8'(MAX_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        HOLDOFF
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      dist_q, dist_d;
    logic            echo_q, echo_d;
    logic            done_q, done_d;
    logic            short_q, short_d;
    logic            trig_m_q, trig_s_q, trig_p_q;
    logic            trig_rise;
    logic [CW-1:0]   echo_len;

    assign trig_rise = trig_s_q & ~trig_p_q;

    // dist_q is stable for the whole measurement, so the width is fixed once latched
    always_comb begin
        if (dist_q == 8'd0 || dist_q > MAX_L) begin
            echo_len = TMO;
        end else begin
            echo_len = {16'd0, dist_q} * CPC;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        cnt_d   = cnt_q;
        dist_d  = dist_q;
        echo_d  = echo_q;
        done_d  = 1'b0;
        short_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            wcnt_d  = '0;
            cnt_d   = '0;
            echo_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (trig_rise) begin
                        state_d = TRIG_HI;
                        wcnt_d  = WW'(1);
                    end
                end
                TRIG_HI: begin
                    if (trig_s_q) begin
                        if (wcnt_q != WMAX) begin
                            wcnt_d = wcnt_q + WW'(1);
                        end
                    end else if (wcnt_q >= WMAX) begin
                        dist_d  = distance_cm;
                        state_d = BURST;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                    end else begin
                        short_d = 1'b1;
                        state_d = IDLE;
                        wcnt_d  = '0;
                    end
                end
                BURST: begin
                    if (cnt_q == BURST_END) begin
                        state_d = ECHO;
                        echo_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ECHO: begin
                    if (cnt_q == echo_len - CW'(1)) begin
                        state_d = HOLDOFF;
                        echo_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt_q == HOLD_END) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    echo_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            cnt_q    <= '0;
            dist_q   <= '0;
            echo_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            trig_m_q <= 1'b0;
            trig_s_q <= 1'b0;
            trig_p_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            cnt_q    <= cnt_d;
            dist_q   <= dist_d;
            echo_q   <= echo_d;
            done_q   <= done_d;
            short_q  <= short_d;
            trig_m_q <= trig;
            trig_s_q <= trig_m_q;
            trig_p_q <= trig_s_q;
        end
    end

    assign echo       = echo_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign short_trig = short_q;

endmodule
